// File: rtl/fsm_rd_responder_if.sv
// fsm_rd_responder_if: initiator-side rd/ws/ds read handshake plus the RAM port of the responder.
// Latency: none (plain wires between the initiator, the responder and the RAM).
// Backpressure: none at this level; the ws/ds handshake carries the flow control.
// Ports (signals): rd, ds, base_addr, wait_cfg, mem_rdata flow toward the responder;
//   ws, rd_data, mem_en, mem_addr, beat_cnt, busy, err flow away from it.
// Modports: master = initiator + RAM model side, slave = responder side.
interface fsm_rd_responder_if #(
    parameter int AW = 8,
    parameter int DW = 16,
    parameter int WW = 4
);
    logic          rd;
    logic          ds;
    logic [AW-1:0] base_addr;
    logic [WW-1:0] wait_cfg;
    logic          ws;
    logic [DW-1:0] rd_data;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic [7:0]    beat_cnt;
    logic          busy;
    logic          err;

    modport master (
        output rd, ds, base_addr, wait_cfg, mem_rdata,
        input  ws, rd_data, mem_en, mem_addr, beat_cnt, busy, err
    );

    modport slave (
        input  rd, ds, base_addr, wait_cfg, mem_rdata,
        output ws, rd_data, mem_en, mem_addr, beat_cnt, busy, err
    );
endinterface

// File: rtl/fsm_rd_responder.sv
// fsm_rd_responder: read-handshake target answering rd requests from a 1-cycle synchronous RAM.
// Latency: data presented (ws low) N+1 cycles after request accept or after each ds, N = wait_cfg.
// Backpressure: none; a missing ds after the data cycle ends the burst (err if rd still high).
// Ports: clk, rst (synchronous, active high), bus (fsm_rd_responder_if.slave):
//   in : rd, ds, base_addr, wait_cfg, mem_rdata
//   out: ws, rd_data, mem_en, mem_addr, beat_cnt, busy, err
module fsm_rd_responder #(
    parameter int AW = 8,
    parameter int DW = 16,
    parameter int WW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    fsm_rd_responder_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [WW-1:0] cnt;
    logic [WW-1:0] cnt_nxt;
    logic [WW-1:0] n_q;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_q;
    logic [7:0]    beat_cnt;
    logic          err;

    logic          accept;
    logic          rearm;
    logic          stray_ds;
    logic          missed_ds;
    logic [AW-1:0] mem_addr_c;

    // Next-state decode. It is needed combinationally because the RAM read
    // must be launched in the cycle before READY so its data lands on time.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        mem_addr_c = addr;
        accept     = 1'b0;
        rearm      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.rd) begin
                    accept     = 1'b1;
                    // addr is not loaded yet, so the RAM sees base_addr directly
                    mem_addr_c = bus.base_addr;
                    if (bus.wait_cfg == '0) begin
                        state_nxt = S_READY;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = bus.wait_cfg - 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (!bus.rd) begin
                    state_nxt = S_IDLE;
                end else if (cnt == '0) begin
                    state_nxt = S_READY;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_READY: begin
                state_nxt = S_ACK;
            end
            S_ACK: begin
                if (bus.ds) begin
                    rearm = 1'b1;
                    if (n_q == '0) begin
                        state_nxt  = S_READY;
                        // zero-wait beat: fetch the incremented address now
                        mem_addr_c = addr + 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = n_q - 1'b1;
                    end
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (rst) begin
            state_nxt = S_IDLE;
        end
    end

    // ds is only meaningful in ACK; anywhere else it is a protocol slip.
    assign stray_ds  = bus.ds && (state != S_ACK);
    // data went out but the initiator neither acknowledged nor released rd
    assign missed_ds = (state == S_ACK) && !bus.ds && bus.rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            n_q      <= '0;
            addr     <= '0;
            data_q   <= '0;
            beat_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                addr     <= bus.base_addr;
                n_q      <= bus.wait_cfg;
                beat_cnt <= '0;
            end
            if (rearm) begin
                addr <= addr + 1'b1;
                if (beat_cnt != 8'hFF) begin
                    beat_cnt <= beat_cnt + 8'd1;
                end
            end
            if (state == S_READY) begin
                data_q <= bus.mem_rdata;
            end
            if (stray_ds || missed_ds) begin
                err <= 1'b1;
            end
        end
    end

    // Handshake outputs decode straight from the state register.
    assign bus.ws       = (state != S_READY);
    assign bus.rd_data  = (state == S_READY) ? bus.mem_rdata : data_q;
    assign bus.mem_en   = (state_nxt == S_READY);
    assign bus.mem_addr = mem_addr_c;
    assign bus.beat_cnt = beat_cnt;
    assign bus.busy     = (state != S_IDLE);
    assign bus.err      = err;

endmodule
